bram_port_arbiter: RTL and testbench

- Shares the single coprocessor block RAM (1024 x 8, one address shared by write port A and read port B) between two requesters.
  - Requester 0: UART command engine.
  - Requester 1: coprocessor compute unit.
- Round-robin grant with optional burst lock and a bounded hold time.
- Tracks BRAM read latency so each requester gets its own read-data-valid strobe.
- Sits between the requesters and blk_mem_gen_0; it is the only driver of the BRAM enables and address.

---
 rtl/coproc_pkg.sv | 26 ++
 rtl/rd_tag_pipe.sv | 28 ++
 rtl/bram_port_arbiter.sv | 132 +++++++++++++
 tb/tb_bram_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coproc_pkg.sv
// Shared types and constants for the coprocessor block-RAM arbiter.
// Other blocks use the state enum, the requester id type and the read-tag struct.
package coproc_pkg;

   localparam int BRAM_ADDR_W = 10;
   localparam int BRAM_DATA_W = 8;
   localparam int BRAM_DEPTH  = 1024;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   typedef logic req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } rd_tag_t;

   function automatic logic [1:0] id_onehot(input req_id_t id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Delay line that carries {valid, requester id} for each issued read.
// Its depth matches the BRAM read latency, so tags and read data arrive together.
module rd_tag_pipe
   import coproc_pkg::*;
#(
   parameter int READ_LATENCY = 1
) (
   input  logic    clk,
   input  logic    rst,
   input  rd_tag_t i_tag,
   output rd_tag_t o_tag
);

   rd_tag_t r_tags [READ_LATENCY];

   // NOTE: every stage is cleared on reset, so no read in flight can raise rvalid once reset is released.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < READ_LATENCY; k++) r_tags[k] <= '0;
      end else begin
         r_tags[0] <= i_tag;
         for (int k = 1; k < READ_LATENCY; k++) r_tags[k] <= r_tags[k-1];
      end
   end

   assign o_tag = r_tags[READ_LATENCY-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter that shares one BRAM between the UART engine (0) and the compute unit (1).
// It supports burst lock and a bounded hold time, and sends each read response back to the requester that issued it.
module bram_port_arbiter
   import coproc_pkg::*;
#(
   parameter int ADDR_W       = BRAM_ADDR_W,
   parameter int DATA_W       = BRAM_DATA_W,
   parameter int READ_LATENCY = 1,
   parameter int MAX_HOLD     = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req,
   input  logic [1:0]        lock,
   input  logic [1:0]        we,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic [1:0]        gnt,
   output logic [1:0]        rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              bram_en,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_din,
   input  logic [DATA_W-1:0] bram_dout
);

   localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

   arb_state_t        r_state;
   req_id_t           r_ptr;
   logic [HOLD_W-1:0] r_hold;
   logic [1:0]        r_gnt;
   logic [1:0]        r_rvalid;
   logic [DATA_W-1:0] r_rdata;

   req_id_t w_own;
   req_id_t w_winner;
   logic    w_issue;
   logic    w_other_req;
   logic    w_force;
   logic    w_release;
   rd_tag_t w_tag_in;
   rd_tag_t w_tag_out;

   assign w_own       = r_gnt[1];
   assign w_issue     = (|r_gnt) & req[w_own];
   assign w_other_req = req[~w_own];
   assign w_force     = w_other_req && (r_hold == HOLD_W'(MAX_HOLD - 1));
   assign w_release   = !req[w_own] || !lock[w_own] || w_force;
   assign w_winner    = (&req) ? r_ptr : req[1];

   // NOTE: defaults come first so that every path assigns every output and no latch is inferred.
   always_comb begin
      bram_en   = w_issue;
      bram_we   = 1'b0;
      bram_addr = '0;
      bram_din  = '0;
      if (w_issue) begin
         bram_we   = we[w_own];
         bram_addr = w_own ? addr1 : addr0;
         bram_din  = w_own ? wdata1 : wdata0;
      end
   end

   // NOTE: state registers use non-blocking assignments, so every branch reads the values from before the clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_gnt   <= 2'b00;
         r_ptr   <= 1'b0;
         r_hold  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_hold <= '0;
               if (|req) begin
                  r_state <= w_winner ? OWN1 : OWN0;
                  r_gnt   <= id_onehot(w_winner);
               end
            end
            OWN0, OWN1: begin
               if (w_release) begin
                  // The next turn goes to the other requester, whether it is now requesting or not.
                  r_ptr  <= ~w_own;
                  r_hold <= '0;
                  if (w_other_req) begin
                     r_state <= w_own ? OWN0 : OWN1;
                     r_gnt   <= id_onehot(~w_own);
                  end else begin
                     r_state <= IDLE;
                     r_gnt   <= 2'b00;
                  end
               end else if (w_other_req) begin
                  r_hold <= r_hold + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_gnt   <= 2'b00;
               r_hold  <= '0;
            end
         endcase
      end
   end

   assign w_tag_in = {w_issue & ~we[w_own], w_own};

   rd_tag_pipe #(.READ_LATENCY(READ_LATENCY)) u_rd_tag_pipe (
      .clk   (clk),
      .rst   (rst),
      .i_tag (w_tag_in),
      .o_tag (w_tag_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rvalid <= 2'b00;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= w_tag_out.valid ? id_onehot(w_tag_out.id) : 2'b00;
         if (w_tag_out.valid) r_rdata <= bram_dout;
      end
   end

   assign gnt    = r_gnt;
   assign rvalid = r_rvalid;
   assign rdata  = r_rdata;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed scenarios with literal expectations, followed by random traffic.
// A per-cycle reference model tracks the owner, the pointer, the hold count, a shadow memory and pending read responses.
module tb_bram_port_arbiter;

   localparam int RL = 2;
   localparam int MH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req, lock, we;
   logic [9:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic [1:0] gnt, rvalid;
   logic [7:0] rdata;
   logic       bram_en, bram_we;
   logic [9:0] bram_addr;
   logic [7:0] bram_din, bram_dout;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   bram_port_arbiter #(.ADDR_W(10), .DATA_W(8), .READ_LATENCY(RL), .MAX_HOLD(MH)) dut (
      .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_din(bram_din), .bram_dout(bram_dout)
   );

   // BRAM model with RL cycles of read latency
   logic [7:0] mem [1024];
   logic [7:0] dpipe [RL];
   always @(posedge clk) begin
      if (bram_en && bram_we) mem[bram_addr] <= bram_din;
      if (bram_en && !bram_we) dpipe[0] <= mem[bram_addr];
      for (int k = 1; k < RL; k++) dpipe[k] <= dpipe[k-1];
   end
   assign bram_dout = dpipe[RL-1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int         due;
      logic [1:0] id;
      logic [7:0] data;
   } resp_t;

   resp_t      rq[$];
   logic [7:0] shadow [1024];

   // Reference model: owner is -1 while nobody holds the RAM
   initial begin : model
      int         owner, ptr, hold, cyc, o;
      logic       own_b, issue;
      logic [1:0] e_gnt, e_rv;
      logic [7:0] e_rd;
      logic [9:0] a;
      owner = -1; ptr = 0; hold = 0; cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            owner = -1; ptr = 0; hold = 0;
            rq.delete();
            check("rst_gnt", 32'(gnt), 0);
            check("rst_rvalid", 32'(rvalid), 0);
            check("rst_rdata", 32'(rdata), 0);
            check("rst_en", 32'(bram_en), 0);
            check("rst_we", 32'(bram_we), 0);
            check("rst_addr", 32'(bram_addr), 0);
            check("rst_din", 32'(bram_din), 0);
         end else begin
            own_b = (owner == 1);
            e_gnt = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
            issue = (owner >= 0) && req[own_b];
            check("m_gnt", 32'(gnt), 32'(e_gnt));
            check("m_en", 32'(bram_en), 32'(issue));
            e_rv = 2'b00;
            e_rd = 8'h00;
            if (rq.size() > 0 && rq[0].due == cyc) begin
               e_rv = rq[0].id;
               e_rd = rq[0].data;
               void'(rq.pop_front());
            end
            check("m_rvalid", 32'(rvalid), 32'(e_rv));
            if (e_rv != 2'b00) check("m_rdata", 32'(rdata), 32'(e_rd));
            if (issue) begin
               a = own_b ? addr1 : addr0;
               check("m_we", 32'(bram_we), 32'(we[own_b]));
               check("m_addr", 32'(bram_addr), 32'(a));
               if (we[own_b]) begin
                  check("m_din", 32'(bram_din), 32'(own_b ? wdata1 : wdata0));
                  shadow[a] = own_b ? wdata1 : wdata0;
               end else begin
                  rq.push_back('{due: cyc + RL + 1, id: (own_b ? 2'b10 : 2'b01), data: shadow[a]});
               end
            end
            if (owner < 0) begin
               if (req != 2'b00) owner = (req == 2'b11) ? ptr : (req[0] ? 0 : 1);
               hold = 0;
            end else begin
               o = 1 - owner;
               if (!req[own_b] || !lock[own_b] || (req[~own_b] && hold == MH - 1)) begin
                  ptr   = o;
                  owner = req[~own_b] ? o : -1;
                  hold  = 0;
               end else if (req[~own_b]) begin
                  hold++;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req = 2'b00; lock = 2'b00; we = 2'b00;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n, got;
      logic seen;
      rst = 1'b1;
      idle_inputs();
      #2;
      // Reset values
      check("a_gnt", 32'(gnt), 0);
      check("a_rvalid", 32'(rvalid), 0);
      check("a_rdata", 32'(rdata), 0);
      check("a_en", 32'(bram_en), 0);
      check("a_addr", 32'(bram_addr), 0);
      step(); step();
      rst = 1'b0;

      // Preload addresses 0..15 with a locked write burst from requester 0
      req = 2'b01; lock = 2'b01; we = 2'b01;
      for (int a = 0; a < 16; a++) begin
         step();
         addr0  = 10'(a);
         wdata0 = (a == 5) ? 8'h3C : (a == 9) ? 8'hAA : 8'(8'hA0 + a);
      end
      step();
      idle_inputs();
      step();

      // Round robin: the first grant goes to requester 0 after reset
      do_reset();
      req = 2'b11; addr0 = 10'd1; addr1 = 10'd2;
      for (int c = 1; c <= 4; c++) begin
         step();
         @(negedge clk);
         check("b_rr_gnt", 32'(gnt), (c % 2 == 1) ? 32'd1 : 32'd2);
      end
      step(); idle_inputs(); step();

      // Single read: grant after one cycle, data RL+1 cycles after the issue cycle
      do_reset();
      req = 2'b01; addr0 = 10'd5;
      @(negedge clk); check("c_gnt_idle", 32'(gnt), 0);
      step(); @(negedge clk);
      check("c_gnt", 32'(gnt), 1);
      check("c_en", 32'(bram_en), 1);
      check("c_addr", 32'(bram_addr), 5);
      step(); req = 2'b00; @(negedge clk); check("c_rv_c2", 32'(rvalid), 0);
      step(); @(negedge clk); check("c_rv_c3", 32'(rvalid), 0);
      step(); @(negedge clk);
      check("c_rv_c4", 32'(rvalid), 1);
      check("c_rdata", 32'(rdata), 32'h3C);
      step(); @(negedge clk);
      check("c_rv_c5", 32'(rvalid), 0);
      check("c_gnt_end", 32'(gnt), 0);

      // Handover while the read is in flight: requester 0 reads 9, then requester 1 writes with lock held
      do_reset();
      req = 2'b11; lock = 2'b10; we = 2'b10; addr0 = 10'd9; addr1 = 10'd3; wdata1 = 8'h55;
      for (int c = 1; c <= 5; c++) begin
         step();
         if (c == 2) req = 2'b10;
         if (c == 5) idle_inputs();
         @(negedge clk);
         check("f_rv1_low", 32'(rvalid[1]), 0);
         if (c == 1) check("f_gnt0", 32'(gnt), 1);
         if (c == 2) begin
            check("f_gnt1", 32'(gnt), 2);
            check("f_we", 32'(bram_we), 1);
         end
         if (c == 4) begin
            check("f_gnt_own1", 32'(gnt), 2);
            check("f_rv", 32'(rvalid), 1);
            check("f_rdata", 32'(rdata), 32'hAA);
         end
      end
      step();

      // Hold limit: requester 0 is locked, requester 1 waits and gets the grant after MH cycles
      do_reset();
      req = 2'b11; lock = 2'b01;
      n = 0; seen = 1'b0;
      for (int c = 0; c < 16 && !seen; c++) begin
         @(negedge clk);
         if (gnt == 2'b01) n++;
         else if (gnt == 2'b10) seen = 1'b1;
         step();
      end
      check("e_switched", 32'(seen), 1);
      check("e_own0_cycles", 32'(n), 32'(MH));
      idle_inputs(); step(); step();

      // Burst lock: 8 writes then 8 reads, with a contiguous grant
      do_reset();
      req = 2'b01; lock = 2'b01;
      got = 0;
      for (int c = 0; c < 30; c++) begin
         step();
         if (c < 16) begin
            we     = (c < 8) ? 2'b01 : 2'b00;
            addr0  = 10'(c % 8);
            wdata0 = 8'(8'h10 + (c % 8));
         end else if (c == 16) begin
            idle_inputs();
         end
         @(negedge clk);
         if (c < 16) begin
            check("d_gnt", 32'(gnt), 1);
            check("d_we", 32'(bram_we), (c < 8) ? 32'd1 : 32'd0);
         end
         if (rvalid[0]) begin
            if (got < 8) check("d_rdata", 32'(rdata), 32'(8'h10 + got));
            got++;
         end
      end
      check("d_read_count", 32'(got), 8);

      // Reset one cycle after a read issue: the read must never complete
      do_reset();
      req = 2'b01; addr0 = 10'd5;
      step(); @(negedge clk); check("g_issue", 32'(bram_en), 1);
      step();
      req = 2'b00;
      rst = 1'b1;
      #1;
      check("g_gnt", 32'(gnt), 0);
      check("g_rvalid", 32'(rvalid), 0);
      check("g_rdata", 32'(rdata), 0);
      check("g_en", 32'(bram_en), 0);
      step(); step();
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("g_no_rvalid", 32'(rvalid), 0);
         step();
      end

      // Random traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 2) == 0) begin
            req  = 2'($urandom_range(0, 3));
            lock = 2'($urandom_range(0, 3));
         end
         we     = 2'($urandom_range(0, 3));
         addr0  = 10'($urandom_range(0, 15));
         addr1  = 10'($urandom_range(0, 15));
         wdata0 = 8'($urandom_range(0, 255));
         wdata1 = 8'($urandom_range(0, 255));
         step();
      end
      rst = 1'b0;
      idle_inputs();
      for (int c = 0; c < RL + 4; c++) step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
